sim_halt_ctrl: RTL and testbench
================================

# sim_halt_ctrl

Simulation halt controller between the core's commit stage and the DPI/testbench boundary. It watches retired instructions for `ebreak` (32'h00100073) and runs a no-commit watchdog. On either event it stalls the core, drains in-flight work for a fixed number of cycles, then presents a latched exit code, PC and cause to the testbench over a req/ack handshake. It also keeps the retired-instruction and cycle counters reported at end of simulation.

## Interface
Parameters:
- `XLEN`, 64, register/PC width
- `DRAIN_CYCLES`, 2, cycles spent in DRAIN before reporting (≥1)
- `WDOG_LIMIT`, 4096, consecutive no-commit cycles that trigger a watchdog halt; 0 disables the watchdog

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `commit_valid`  in  1  one instruction retires this cycle
- `commit_inst`  in  32  encoding of the retiring instruction
- `commit_pc`  in  XLEN  PC of the retiring instruction
- `R10`  in  XLEN  current a0 value, coherent with the commit
- `halt_ack`  in  1  testbench accepts the halt report
- `stall`  out  1  freeze fetch/commit
- `halt_req`  out  1  halt report valid
- `halt_cause`  out  2  0 none, 1 ebreak, 2 watchdog
- `halt_code`  out  32  exit code
- `halt_pc`  out  XLEN  PC of the halting instruction or last commit
- `done`  out  1  simulation finished
- `inst_count`  out  64  retired instructions
- `cycle_count`  out  64  cycles since reset

## Operation
- FSM states: RUN, DRAIN, REPORT, DONE. Reset state is RUN.
- RUN:
  - Each `commit_valid` increments `inst_count` and clears the idle counter.
  - `commit_valid && commit_inst == 32'h00100073` latches `halt_code = R10[31:0]`, `halt_pc = commit_pc`, `halt_cause = 1`, then goes to DRAIN. The `ebreak` itself is counted.
  - With `WDOG_LIMIT != 0`: if the idle counter equals `WDOG_LIMIT-1` and `commit_valid` is 0, latch `halt_cause = 2`, `halt_code = 32'h1`, `halt_pc` = PC of the last commit (0 if none), then go to DRAIN.
- DRAIN: the drain counter counts `DRAIN_CYCLES` cycles, then goes to REPORT. `commit_valid` is ignored: no counting, no re-trigger.
- REPORT: `halt_req` = 1. On `halt_ack` = 1, go to DONE. `halt_ack` in any other state is ignored.
- DONE: terminal until reset. `done` = 1.
- `stall` = (state != RUN). `halt_req` = (state == REPORT). `done` = (state == DONE). All three decode from the registered state.
- `halt_*` outputs are latched and stay stable from DRAIN entry until reset.
- `cycle_count` increments every cycle in RUN, DRAIN and REPORT, and freezes in DONE.
- Counters are 64-bit and wrap modulo 2^64. The idle counter saturates at `WDOG_LIMIT-1`.

## Timing
- Reset (async assert, synchronous release): state RUN; all counters 0; `stall`, `halt_req`, `done`, `halt_cause`, `halt_code`, `halt_pc` all 0.
- Reset asserted mid-DRAIN or mid-REPORT aborts immediately to the reset values. No report is issued.
- Ebreak sampled at edge T:
  - `stall` = 1 from T+1.
  - `halt_req` = 1 from T+1+DRAIN_CYCLES.
- Ack sampled at edge A while in REPORT: `halt_req` = 0 and `done` = 1 from A+1. Handshake latency is 1 cycle.
- Ebreak and a watchdog expiry in the same cycle: a commit is present, so the idle counter clears and the ebreak wins with cause 1.
- A non-ebreak commit on the watchdog expiry cycle clears the counter and prevents the halt.
- `commit_inst` = ebreak with `commit_valid` = 0 is not a halt.

## Test plan
- Reset, 3 plain commits, then ebreak at PC 0x80000010 with R10 = 0 → `inst_count` = 4; `stall` rises 1 cycle after; `halt_req` rises 3 cycles after (DRAIN_CYCLES = 2); cause = 1, code = 0, pc = 0x80000010.
- Ebreak with R10 = 0xFFFFFFFF_00000007 → `halt_code` = 7. Commits driven during DRAIN leave `inst_count` unchanged.
- `halt_ack` held 0 for 10 cycles in REPORT → `halt_req` stays 1 and `cycle_count` keeps advancing. Ack pulse → `done` = 1 next cycle and `cycle_count` frozen. A later ack has no effect.
- WDOG_LIMIT = 8, last commit at PC 0x80000004, no further commits → cause = 2, code = 1, pc = 0x80000004 after 8 idle cycles. A second run with a commit on the 8th idle cycle → no halt.
- Reset asserted asynchronously during REPORT → all outputs 0 in the same cycle. After release, a new ebreak completes a full RUN→DRAIN→REPORT→DONE sequence.

Source files
------------

// File: rtl/sim_halt_ctrl.sv
// sim_halt_ctrl: watches the commit stream for ebreak and runs a no-commit
// watchdog. On either event it stalls the core, drains for a fixed number of
// cycles, then reports exit code / PC / cause to the testbench over a
// req/ack handshake. Also keeps the retired-instruction and cycle counters.
module sim_halt_ctrl #(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 2,
    parameter int WDOG_LIMIT   = 4096
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [31:0]     commit_inst,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] R10,
    input  logic            halt_ack,
    output logic            stall,
    output logic            halt_req,
    output logic [1:0]      halt_cause,
    output logic [31:0]     halt_code,
    output logic [XLEN-1:0] halt_pc,
    output logic            done,
    output logic [63:0]     inst_count,
    output logic [63:0]     cycle_count
);

    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    // Idle counter only needs to reach WDOG_LIMIT-1; drain counter DRAIN_CYCLES-1.
    localparam int IDLE_W  = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'((WDOG_LIMIT > 0) ? WDOG_LIMIT - 1 : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam bit                 WDOG_EN    = (WDOG_LIMIT != 0);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_REPORT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [IDLE_W-1:0]    r_idle;
    logic [DRAIN_W-1:0]   r_drain;
    logic [XLEN-1:0]      r_last_pc;
    logic [1:0]           r_cause;
    logic [31:0]          r_code;
    logic [XLEN-1:0]      r_pc;
    logic [63:0]          r_inst_cnt;
    logic [63:0]          r_cycle_cnt;

    logic w_in_run;
    logic w_ebreak;
    logic w_wdog_fire;
    logic w_halt_ebreak;
    logic w_halt_wdog;

    // Only the low word of a0 becomes the exit code.
    generate
        if (XLEN > 32) begin : g_r10_hi
            logic w_unused_r10_hi;
            assign w_unused_r10_hi = ^R10[XLEN-1:32];
        end
    endgenerate

    assign w_in_run    = (r_state == S_RUN);
    assign w_ebreak    = commit_valid && (commit_inst == EBREAK_INST);
    // A commit in the expiry cycle clears the idle count, so it always blocks the watchdog.
    assign w_wdog_fire = WDOG_EN && !commit_valid && (r_idle == IDLE_MAX);
    assign w_halt_ebreak = w_in_run && w_ebreak;
    assign w_halt_wdog   = w_in_run && w_wdog_fire;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN: begin
                if (w_ebreak || w_wdog_fire) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                if (halt_ack) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    // Consecutive no-commit counter, saturating at WDOG_LIMIT-1; also remembers the last commit PC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idle    <= '0;
            r_last_pc <= '0;
        end else if (w_in_run) begin
            if (commit_valid) begin
                r_idle    <= '0;
                r_last_pc <= commit_pc;
            end else if (WDOG_EN && (r_idle != IDLE_MAX)) begin
                r_idle <= r_idle + IDLE_W'(1);
            end
        end else begin
            r_idle <= '0;
        end
    end

    // Drain timer: counts DRAIN_CYCLES cycles spent in DRAIN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_drain <= '0;
        end else if ((r_state == S_DRAIN) && (r_drain != DRAIN_LAST)) begin
            r_drain <= r_drain + DRAIN_W'(1);
        end else begin
            r_drain <= '0;
        end
    end

    // Halt report latch: captured once on leaving RUN, held until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cause <= 2'd0;
            r_code  <= 32'd0;
            r_pc    <= '0;
        end else if (w_halt_ebreak) begin
            r_cause <= 2'd1;
            r_code  <= R10[31:0];
            r_pc    <= commit_pc;
        end else if (w_halt_wdog) begin
            r_cause <= 2'd2;
            r_code  <= 32'd1;
            r_pc    <= r_last_pc;
        end
    end

    // Retired-instruction and cycle counters; both wrap at 2^64.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_inst_cnt  <= 64'd0;
            r_cycle_cnt <= 64'd0;
        end else begin
            if (w_in_run && commit_valid) begin
                r_inst_cnt <= r_inst_cnt + 64'd1;
            end
            if (r_state != S_DONE) begin
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            end
        end
    end

    assign stall       = (r_state != S_RUN);
    assign halt_req    = (r_state == S_REPORT);
    assign done        = (r_state == S_DONE);
    assign halt_cause  = r_cause;
    assign halt_code   = r_code;
    assign halt_pc     = r_pc;
    assign inst_count  = r_inst_cnt;
    assign cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_sim_halt_ctrl.sv
// Self-checking bench for sim_halt_ctrl: directed scenario tasks plus a
// randomized run checked against an event-based reference model.
module tb_sim_halt_ctrl;

    localparam int XLEN  = 64;
    localparam int DRAIN = 2;
    localparam int WDOG  = 8;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic            clock;
    logic            reset;
    logic            commit_valid;
    logic [31:0]     commit_inst;
    logic [XLEN-1:0] commit_pc;
    logic [XLEN-1:0] R10;
    logic            halt_ack;
    logic            stall;
    logic            halt_req;
    logic [1:0]      halt_cause;
    logic [31:0]     halt_code;
    logic [XLEN-1:0] halt_pc;
    logic            done;
    logic [63:0]     inst_count;
    logic [63:0]     cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    sim_halt_ctrl #(
        .XLEN(XLEN),
        .DRAIN_CYCLES(DRAIN),
        .WDOG_LIMIT(WDOG)
    ) dut (
        .clock(clock),
        .reset(reset),
        .commit_valid(commit_valid),
        .commit_inst(commit_inst),
        .commit_pc(commit_pc),
        .R10(R10),
        .halt_ack(halt_ack),
        .stall(stall),
        .halt_req(halt_req),
        .halt_cause(halt_cause),
        .halt_code(halt_code),
        .halt_pc(halt_pc),
        .done(done),
        .inst_count(inst_count),
        .cycle_count(cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [228:0] dut_vec;
    assign dut_vec = {stall, halt_req, done, halt_cause, halt_code, halt_pc, inst_count, cycle_count};

    // Reference model: tracks the halt as events (halted?, edges since trigger, acked?).
    bit          m_halted;
    bit          m_done;
    int          m_since;
    int          m_idle;
    logic [1:0]  m_cause;
    logic [31:0] m_code;
    logic [63:0] m_pc;
    logic [63:0] m_last_pc;
    logic [63:0] m_inst;
    logic [63:0] m_cyc;

    task automatic model_reset();
        m_halted = 0; m_done = 0; m_since = 0; m_idle = 0;
        m_cause = 0; m_code = 0; m_pc = 0; m_last_pc = 0; m_inst = 0; m_cyc = 0;
    endtask

    task automatic model_edge();
        if (!m_done) m_cyc = m_cyc + 1;
        if (!m_halted) begin
            if (commit_valid) begin
                m_inst    = m_inst + 1;
                m_idle    = 0;
                m_last_pc = commit_pc;
                if (commit_inst == EBREAK) begin
                    m_halted = 1; m_since = 0;
                    m_cause = 2'd1; m_code = R10[31:0]; m_pc = commit_pc;
                end
            end else begin
                m_idle = m_idle + 1;
                if (m_idle >= WDOG) begin
                    m_halted = 1; m_since = 0;
                    m_cause = 2'd2; m_code = 32'd1; m_pc = m_last_pc;
                end
            end
        end else if (!m_done) begin
            if (m_since >= DRAIN && halt_ack) m_done = 1;
            m_since = m_since + 1;
        end
    endtask

    function automatic logic [228:0] exp_vec();
        logic req;
        req = m_halted && !m_done && (m_since >= DRAIN);
        return {m_halted, req, m_done, m_cause, m_code, m_pc, m_inst, m_cyc};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after.
    task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic [63:0] r10, input logic ack);
        commit_valid = v; commit_inst = inst; commit_pc = pc; R10 = r10; halt_ack = ack;
        @(posedge clock);
        if (reset) model_edge(); else model_reset();
        #1;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, NOP, 64'd0, 64'd0, ack);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        commit_valid = 0; commit_inst = 0; commit_pc = 0; R10 = 0; halt_ack = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec !== 229'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", dut_vec);
        end
        idle(1'b0);
        n_checks++;
        if (cycle_count !== 64'd1) begin
            n_fail++; $display("FAIL reset_first_cycle got=%0d exp=1", cycle_count);
        end
        n_checks++;
        if (stall !== 1'b0 || inst_count !== 64'd0) begin
            n_fail++; $display("FAIL reset_idle got stall=%b inst=%0d exp stall=0 inst=0", stall, inst_count);
        end
    endtask

    task automatic test_ebreak_basic();
        logic [63:0] cyc_frozen;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, NOP, 64'h8000_0000 + 64'(4 * i), 64'(i + 100), 1'b0);
        step(1'b1, EBREAK, 64'h8000_0010, 64'd0, 1'b0);
        n_checks++;
        if (inst_count !== 64'd4 || stall !== 1'b1 || halt_req !== 1'b0) begin
            n_fail++; $display("FAIL ebreak_entry got inst=%0d stall=%b req=%b exp inst=4 stall=1 req=0",
                               inst_count, stall, halt_req);
        end
        idle(1'b0);
        n_checks++;
        if (halt_req !== 1'b0) begin
            n_fail++; $display("FAIL ebreak_drain_req got=%b exp=0", halt_req);
        end
        idle(1'b0);
        n_checks++;
        if (halt_req !== 1'b1 || halt_cause !== 2'd1 || halt_code !== 32'd0 || halt_pc !== 64'h8000_0010) begin
            n_fail++; $display("FAIL ebreak_report got req=%b cause=%0d code=%h pc=%h exp req=1 cause=1 code=0 pc=80000010",
                               halt_req, halt_cause, halt_code, halt_pc);
        end
        idle(1'b1);
        cyc_frozen = m_cyc;
        n_checks++;
        if (done !== 1'b1 || halt_req !== 1'b0 || cycle_count !== cyc_frozen) begin
            n_fail++; $display("FAIL ebreak_done got done=%b req=%b cyc=%0d exp done=1 req=0 cyc=%0d",
                               done, halt_req, cycle_count, cyc_frozen);
        end
        $display("txn ebreak_basic: cause=%0d code=%h pc=%h inst=%0d", halt_cause, halt_code, halt_pc, inst_count);
    endtask

    // Commits during DRAIN are ignored; then REPORT is held without ack.
    task automatic test_drain_and_report_hold();
        logic [63:0] cyc_prev;
        do_reset();
        step(1'b1, NOP, 64'h8000_0100, 64'd1, 1'b0);
        step(1'b1, NOP, 64'h8000_0104, 64'd2, 1'b0);
        step(1'b1, EBREAK, 64'h8000_0108, 64'hFFFF_FFFF_0000_0007, 1'b0);
        step(1'b1, EBREAK, 64'h8000_0200, 64'h55, 1'b1);
        step(1'b1, NOP, 64'h8000_0204, 64'h66, 1'b0);
        n_checks++;
        if (inst_count !== 64'd3 || halt_code !== 32'd7 || halt_pc !== 64'h8000_0108 || halt_req !== 1'b1) begin
            n_fail++; $display("FAIL drain_ignore got inst=%0d code=%h pc=%h req=%b exp inst=3 code=7 pc=80000108 req=1",
                               inst_count, halt_code, halt_pc, halt_req);
        end
        for (int i = 0; i < 10; i++) begin
            cyc_prev = cycle_count;
            step(1'b1, NOP, 64'd0, 64'd0, 1'b0);
            n_checks++;
            if (halt_req !== 1'b1 || done !== 1'b0 || cycle_count !== cyc_prev + 64'd1) begin
                n_fail++; $display("FAIL report_hold i=%0d got req=%b done=%b cyc=%0d exp req=1 done=0 cyc=%0d",
                                   i, halt_req, done, cycle_count, cyc_prev + 64'd1);
            end
        end
        idle(1'b1);
        cyc_prev = cycle_count;
        n_checks++;
        if (done !== 1'b1 || halt_req !== 1'b0) begin
            n_fail++; $display("FAIL report_ack got done=%b req=%b exp done=1 req=0", done, halt_req);
        end
        for (int i = 0; i < 4; i++) idle(1'(i % 2));
        n_checks++;
        if (done !== 1'b1 || cycle_count !== cyc_prev || halt_code !== 32'd7 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL done_frozen got done=%b cyc=%0d code=%h exp done=1 cyc=%0d code=7",
                               done, cycle_count, halt_code, cyc_prev);
        end
        $display("txn drain_report: cause=%0d code=%h pc=%h inst=%0d", halt_cause, halt_code, halt_pc, inst_count);
    endtask

    task automatic test_watchdog();
        // Expiry after 8 idle cycles following a commit.
        do_reset();
        step(1'b1, NOP, 64'h8000_0004, 64'd9, 1'b0);
        for (int i = 0; i < WDOG - 1; i++) idle(1'b0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL wdog_early got stall=%b exp=0", stall);
        end
        idle(1'b0);
        n_checks++;
        if (stall !== 1'b1 || halt_cause !== 2'd2 || halt_code !== 32'd1 || halt_pc !== 64'h8000_0004) begin
            n_fail++; $display("FAIL wdog_fire got stall=%b cause=%0d code=%h pc=%h exp stall=1 cause=2 code=1 pc=80000004",
                               stall, halt_cause, halt_code, halt_pc);
        end
        $display("txn wdog_fire: cause=%0d code=%h pc=%h", halt_cause, halt_code, halt_pc);
        // Commit on the 8th idle cycle prevents the halt and restarts the count.
        do_reset();
        step(1'b1, NOP, 64'h8000_0004, 64'd9, 1'b0);
        for (int i = 0; i < WDOG - 1; i++) idle(1'b0);
        step(1'b1, NOP, 64'h8000_0008, 64'd9, 1'b0);
        for (int i = 0; i < WDOG - 1; i++) idle(1'b0);
        n_checks++;
        if (stall !== 1'b0 || halt_cause !== 2'd0 || inst_count !== 64'd2) begin
            n_fail++; $display("FAIL wdog_rescued got stall=%b cause=%0d inst=%0d exp stall=0 cause=0 inst=2",
                               stall, halt_cause, inst_count);
        end
        // Ebreak on the expiry cycle wins with cause 1.
        do_reset();
        for (int i = 0; i < WDOG - 1; i++) idle(1'b0);
        step(1'b1, EBREAK, 64'h8000_0040, 64'd5, 1'b0);
        n_checks++;
        if (halt_cause !== 2'd1 || halt_code !== 32'd5 || halt_pc !== 64'h8000_0040) begin
            n_fail++; $display("FAIL wdog_vs_ebreak got cause=%0d code=%h pc=%h exp cause=1 code=5 pc=80000040",
                               halt_cause, halt_code, halt_pc);
        end
        // Ebreak encoding without valid is no halt; with no commits at all the watchdog reports pc 0.
        do_reset();
        for (int i = 0; i < WDOG - 1; i++) step(1'b0, EBREAK, 64'h8000_0080, 64'd3, 1'b0);
        n_checks++;
        if (stall !== 1'b0 || inst_count !== 64'd0) begin
            n_fail++; $display("FAIL ebreak_not_valid got stall=%b inst=%0d exp stall=0 inst=0", stall, inst_count);
        end
        idle(1'b0);
        n_checks++;
        if (halt_cause !== 2'd2 || halt_pc !== 64'd0 || halt_code !== 32'd1) begin
            n_fail++; $display("FAIL wdog_no_commit got cause=%0d pc=%h code=%h exp cause=2 pc=0 code=1",
                               halt_cause, halt_pc, halt_code);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, EBREAK, 64'h8000_0300, 64'd42, 1'b0);
        idle(1'b0);
        idle(1'b0);
        n_checks++;
        if (halt_req !== 1'b1) begin
            n_fail++; $display("FAIL async_pre_report got req=%b exp=1", halt_req);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== 229'd0) begin
            n_fail++; $display("FAIL async_reset_outputs got=%h exp=0", dut_vec);
        end
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        step(1'b1, EBREAK, 64'h8000_0400, 64'd11, 1'b0);
        for (int i = 0; i < DRAIN + 1; i++) begin
            idle(i == DRAIN ? 1'b1 : 1'b0);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL async_rerun i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (done !== 1'b1 || halt_code !== 32'd11 || inst_count !== 64'd1) begin
            n_fail++; $display("FAIL async_rerun_done got done=%b code=%h inst=%0d exp done=1 code=b inst=1",
                               done, halt_code, inst_count);
        end
        $display("txn async_rerun: cause=%0d code=%h pc=%h", halt_cause, halt_code, halt_pc);
    endtask

    task automatic test_random();
        int p_valid;
        logic [31:0] inst;
        for (int run = 0; run < 10; run++) begin
            do_reset();
            p_valid = $urandom_range(15, 90);
            for (int c = 0; c < 150; c++) begin
                inst = ($urandom_range(0, 9) == 0) ? EBREAK : $urandom;
                step(($urandom_range(0, 99) < p_valid) ? 1'b1 : 1'b0, inst,
                     {$urandom, $urandom}, {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL random run=%0d cyc=%0d got=%h exp=%h", run, c, dut_vec, exp_vec());
                end
            end
            $display("txn random run=%0d p=%0d: done=%b cause=%0d code=%h inst=%0d cyc=%0d",
                     run, p_valid, done, halt_cause, halt_code, inst_count, cycle_count);
        end
    endtask

    initial begin
        reset = 1'b0;
        commit_valid = 0; commit_inst = 0; commit_pc = 0; R10 = 0; halt_ack = 0;
        test_reset();
        test_ebreak_basic();
        test_drain_and_report_hold();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
